// File: rtl/uart_rx_ext.sv
// -----------------------------------------------------------------------------
// uart_rx_ext -- oversampling asynchronous serial receiver
//
// Receives start + DATA_BITS data bits (LSB first) + optional parity bit +
// STOP_BITS stop bits from an idle-high line.  Each bit is sampled near its
// centre by counting CLKS_PER_BIT clocks from the centre of the start bit.
// A frame whose stop bit reads low is reported with a frame error, and the
// receiver then waits for the line to go high again (break handling) before
// it will look for a new start bit.
//
// Optional feature: define UART_RX_PARITY_EN to add the parity bit and the
// parity check (PARITY_ODD selects odd parity).  Without the macro there is
// no parity state or logic and o_Parity_Err is constant 0.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (>= 4)
//   DATA_BITS     data bits per frame (5..9)
//   STOP_BITS     stop bits per frame (1 or 2)
//   PARITY_ODD    0 = even parity, 1 = odd parity (parity builds only)
//
// Ports:
//   i_Clock       single clock, all flops on its rising edge
//   i_Rst_n       asynchronous active-low reset
//   i_Rx_Serial   asynchronous serial input, idle high
//   o_Rx_DV       one-clock strobe when a frame has been received
//   o_Rx_Byte     received data, LSB = first data bit, held until next strobe
//   o_Frame_Err   stop-bit error, valid only while o_Rx_DV is high
//   o_Parity_Err  parity error, valid only while o_Rx_DV is high
//   o_Busy        high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_ext #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Frame_Err,
  output logic                 o_Parity_Err,
  output logic                 o_Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  // Centre of the start bit; everything after is one full bit period apart.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  // Reject illegal configurations at elaboration time.
  if ((CLKS_PER_BIT < 4) || (DATA_BITS < 5) || (DATA_BITS > 9) ||
      ((STOP_BITS != 1) && (STOP_BITS != 2)) ||
      ((PARITY_ODD != 0) && (PARITY_ODD != 1))) begin : g_bad_config
    $error("uart_rx_ext: illegal parameter combination");
  end

  // Encoding 3'd7 (and 3'd3 without parity) is unused and recovers to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY  = 3'd3,
`endif
    ST_STOP    = 3'd4,
    ST_CLEANUP = 3'd5,
    ST_BREAK   = 3'd6
  } state_t;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  // High when the received data plus parity bit disagree with the parity sense.
  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                           input logic                 par_bit,
                                           input logic                 odd);
    return (^data) ^ par_bit ^ odd;
  endfunction
`endif

  logic                 rx_meta_r;
  logic                 rx_sync_r;
  state_t               state_r;
  state_t               state_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_s;
  logic [IDX_W-1:0]     idx_r;
  logic [IDX_W-1:0]     idx_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_s;
  logic                 ferr_r;
  logic                 ferr_s;
  logic                 ferr_now_s;
  logic                 dv_r;
  logic                 dv_s;
  logic [DATA_BITS-1:0] byte_r;
  logic [DATA_BITS-1:0] byte_s;
  logic                 ferr_out_r;
  logic                 ferr_out_s;
  logic                 busy_r;
`ifdef UART_RX_PARITY_EN
  logic                 perr_r;
  logic                 perr_s;
  logic                 perr_out_r;
  logic                 perr_out_s;
`endif

  // Two-flop synchroniser for the asynchronous line; resets to the idle level.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= i_Rx_Serial;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Next-state and datapath logic for the receive FSM.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    idx_s      = idx_r;
    shift_s    = shift_r;
    ferr_s     = ferr_r;
    ferr_now_s = ferr_r;
    dv_s       = 1'b0;
    byte_s     = byte_r;
    ferr_out_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_s     = perr_r;
    perr_out_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        cnt_s  = CNT_ZERO;
        idx_s  = IDX_ZERO;
        ferr_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_s = 1'b0;
`endif
        if (rx_sync_r == 1'b0) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_START: begin
        if (cnt_r == CNT_HALF) begin
          cnt_s = CNT_ZERO;
          // A line that is high again at mid start bit was only a glitch.
          if (rx_sync_r == 1'b0) begin
            state_s = ST_DATA;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      ST_DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s = CNT_ZERO;
          // Shifting in from the top leaves the first bit at the LSB.
          shift_s = {rx_sync_r, shift_r[DATA_BITS-1:1]};
          if (idx_r == DATA_LAST) begin
            idx_s = IDX_ZERO;
`ifdef UART_RX_PARITY_EN
            state_s = ST_PARITY;
`else
            state_s = ST_STOP;
`endif
          end else begin
            idx_s = idx_r + IDX_ONE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s   = CNT_ZERO;
          perr_s  = parity_mismatch(shift_r, rx_sync_r, PAR_ODD);
          state_s = ST_STOP;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
`endif

      ST_STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s      = CNT_ZERO;
          ferr_now_s = ferr_r | ~rx_sync_r;
          ferr_s     = ferr_now_s;
          if (idx_r == STOP_LAST) begin
            // Last stop sample: publish the frame on the next clock.
            idx_s      = IDX_ZERO;
            dv_s       = 1'b1;
            byte_s     = shift_r;
            ferr_out_s = ferr_now_s;
`ifdef UART_RX_PARITY_EN
            perr_out_s = perr_r;
`endif
            state_s    = ST_CLEANUP;
          end else begin
            idx_s = idx_r + IDX_ONE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      ST_CLEANUP: begin
        // A bad stop bit may mean a break; wait for the line to idle first.
        if (ferr_r) begin
          state_s = ST_BREAK;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_BREAK: begin
        if (rx_sync_r == 1'b1) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BREAK;
        end
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
        idx_s   = IDX_ZERO;
      end
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      idx_r      <= IDX_ZERO;
      shift_r    <= {DATA_BITS{1'b0}};
      ferr_r     <= 1'b0;
      dv_r       <= 1'b0;
      byte_r     <= {DATA_BITS{1'b0}};
      ferr_out_r <= 1'b0;
      busy_r     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_r     <= 1'b0;
      perr_out_r <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      idx_r      <= idx_s;
      shift_r    <= shift_s;
      ferr_r     <= ferr_s;
      dv_r       <= dv_s;
      byte_r     <= byte_s;
      ferr_out_r <= ferr_out_s;
      // Busy tracks the state register so it is exactly "not IDLE".
      busy_r     <= (state_s != ST_IDLE);
`ifdef UART_RX_PARITY_EN
      perr_r     <= perr_s;
      perr_out_r <= perr_out_s;
`endif
    end
  end

  assign o_Rx_DV     = dv_r;
  assign o_Rx_Byte   = byte_r;
  assign o_Frame_Err = ferr_out_r;
  assign o_Busy      = busy_r;
`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err = perr_out_r;
`else
  assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, clocks per serial bit (legal >= 4).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
REQ-004 SHALL have parameter PARITY_ODD, default 0, parity sense (0 even, 1 odd); used only when UART_RX_PARITY_EN is defined.
REQ-005 SHALL have port i_Clock, input, 1, the single clock; all flops on its rising edge.
REQ-006 SHALL have port i_Rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port i_Rx_Serial, input, 1, asynchronous serial line (idle high).
REQ-008 SHALL have port o_Rx_DV, output, 1, one-cycle frame-complete strobe.
REQ-009 SHALL have port o_Rx_Byte, output, DATA_BITS, received data, LSB = first data bit.
REQ-010 SHALL have port o_Frame_Err, output, 1, stop-bit error flag, valid with o_Rx_DV.
REQ-011 SHALL have port o_Parity_Err, output, 1, parity error flag, valid with o_Rx_DV.
REQ-012 SHALL have port o_Busy, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL pass i_Rx_Serial through a 2-flop synchroniser; all decisions use the synchronised value.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, CLEANUP, BREAK.
REQ-015 IDLE: clear clock count and bit index; go to START when the synchronised line is 0.
REQ-016 START: at count (CLKS_PER_BIT-1)/2, line 0 -> clear count, go to DATA; line 1 -> IDLE with no strobe and no flags (glitch reject).
REQ-017 DATA: sample each bit after CLKS_PER_BIT-1 further clocks, store at the bit index, LSB first; after bit DATA_BITS-1, go to PARITY if enabled, else STOP.
REQ-018 PARITY: sample once, one bit time after the last data bit; flag an error when data XOR parity bit XOR PARITY_ODD is not 0.
REQ-019 STOP: sample STOP_BITS bits, one bit time apart; any stop sample 0 sets the frame error.
REQ-020 After the last stop sample, o_Rx_DV SHALL be 1 for exactly the next clock, with o_Rx_Byte and both error flags valid; the state then moves to CLEANUP.
REQ-021 The strobe SHALL fire even when error flags are set; error flags SHALL be 0 whenever o_Rx_DV is 0.
REQ-022 CLEANUP: lasts one clock, then goes to IDLE if no frame error, else to BREAK.
REQ-023 BREAK: hold until the synchronised line is 1, then go to IDLE; a low line SHALL never start a new frame here.
REQ-024 o_Rx_Byte SHALL hold its value until the next strobe.
REQ-025 Clock counter width SHALL be $clog2(CLKS_PER_BIT).
REQ-026 Bit index width SHALL be $clog2(DATA_BITS+1).
REQ-027 Counters SHALL never wrap mid-bit.
REQ-028 Back-to-back frames (next start immediately after the last stop bit) SHALL be received without loss.
REQ-029 An unused state encoding SHALL return to IDLE on the next clock.

Reset
REQ-030 While i_Rst_n = 0, and immediately on its assertion: state IDLE, counters 0, synchroniser flops 1, o_Rx_Byte 0, o_Rx_DV/o_Frame_Err/o_Parity_Err/o_Busy 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no strobe.
REQ-032 The first frame starting after reset release SHALL be received normally.

Configuration
REQ-033 Macro UART_RX_PARITY_EN defined: PARITY state present; frame = start + DATA_BITS + parity + STOP_BITS.
REQ-034 Macro UART_RX_PARITY_EN undefined: no PARITY state or parity logic; frame = start + DATA_BITS + STOP_BITS; o_Parity_Err tied to 0.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-035 8N1 frame 0x55 -> exactly one o_Rx_DV pulse, o_Rx_Byte=0x55, both error flags 0, o_Busy drops after CLEANUP.
REQ-036 Line low for 1 clock, then high -> no o_Rx_DV, state back to IDLE within 3 clocks; a following 0xC3 frame is received correctly.
REQ-037 Frame 0xA3 with stop bit 0, line held low for 20 clocks after -> DV with 0xA3 and o_Frame_Err=1; no further DV until the line returns high and a new frame arrives.
REQ-038 Parity enabled, PARITY_ODD=0, 0x07 sent with parity bit 0 -> DV with 0x07 and o_Parity_Err=1; same data with parity bit 1 -> o_Parity_Err=0.
REQ-039 i_Rst_n pulsed low during data bit 3 -> all outputs 0 immediately, no DV for the aborted frame; a following 0x3C frame yields DV with 0x3C.
REQ-040 DATA_BITS=5, STOP_BITS=2: three back-to-back frames 0x1F, 0x00, 0x15 -> three DV pulses in order with those values, no errors.
